// File: rtl/rram_pkg.sv
// Shared opcodes, address field widths and FSM state encoding for the RRAM host sequencer.
package rram_pkg;

    localparam logic [3:0] OP_WRITE = 4'b0100;
    localparam logic [3:0] OP_WCONF = 4'b0010;
    localparam logic [3:0] OP_READ  = 4'b0001;
    localparam logic [3:0] OP_RCONF = 4'b0011;

    localparam int BLK_W  = 2;
    localparam int ROW_W  = 5;
    localparam int COL_W  = 5;
    localparam int ADDR_W = BLK_W + ROW_W + COL_W;
    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CE_SETUP,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_CONF,
        S_GUARD,
        S_WAIT_RB,
        S_RDATA,
        S_DONE
    } state_t;

endpackage

// File: rtl/rram_bit_shifter.sv
// 32-bit MSB-first shift register shared by serial write and serial read, with its bit counter.
module rram_bit_shifter
    import rram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_shift,
    input  logic              i_bit,
    output logic              o_msb,
    output logic              o_last,
    output logic [DATA_W-1:0] o_data_nxt
);

    localparam int BC_W = $clog2(DATA_W);

    logic [DATA_W-1:0] r_data;
    logic [BC_W-1:0]   r_bit_cnt;

    // The value after the pending shift, so the final read bit can be captured in the same edge.
    assign o_data_nxt = {r_data[DATA_W-2:0], i_bit};
    assign o_msb      = r_data[DATA_W-1];
    assign o_last     = (r_bit_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_bit_cnt <= '0;
        end else if (i_load) begin
            r_data    <= i_data;
            r_bit_cnt <= BC_W'(DATA_W - 1);
        end else if (i_shift) begin
            r_data    <= o_data_nxt;
            r_bit_cnt <= r_bit_cnt - BC_W'(1);
        end
    end

endmodule

// File: rtl/rram_host_seq.sv
// Host-side sequencer: turns one write/read request into the RRAM CE/CLE/ALE/WE/RE/IO/Dinout protocol.
//   state      | meaning
//   IDLE       | req_ready high, waiting for a request
//   CE_SETUP   | CE low, no strobes
//   CMD        | command nibble on IO, CLE high
//   ADDR       | three address nibbles, MSB nibble first, ALE high
//   WDATA      | 32 write bits on dinout_out, MSB first
//   CONF       | confirm command nibble, CLE high
//   GUARD      | two idle cycles so the device can pull RB low
//   WAIT_RB    | wait for RB high or busy timeout
//   RDATA      | 32 RE pulses, bits shifted in MSB first
//   DONE       | rsp_valid pulse, CE back high
module rram_host_seq
    import rram_pkg::*;
#(
    parameter logic [3:0] CMD_WRITE    = OP_WRITE,
    parameter logic [3:0] CMD_WCONF    = OP_WCONF,
    parameter logic [3:0] CMD_READ     = OP_READ,
    parameter logic [3:0] CMD_RCONF    = OP_RCONF,
    parameter int         BUSY_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              CE,
    output logic              CLE,
    output logic              ALE,
    output logic              WE,
    output logic              RE,
    output logic [3:0]        IO,
    output logic              io_oe,
    output logic              dinout_out,
    output logic              dinout_oe,
    input  logic              dinout_in,
    input  logic              RB
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    state_t            r_state, w_state_nxt;
    logic              r_ph, w_ph_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              w_timeout_nxt;
    logic              r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        w_io_nxt;
    logic              w_accept, w_shift, w_last;
    logic [DATA_W-1:0] w_shift_data;

    assign w_accept = (r_state == S_IDLE) && req_valid && req_ready;
    assign w_shift  = r_ph && ((r_state == S_WDATA) || (r_state == S_RDATA));

    rram_bit_shifter u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_data     (req_wdata),
        .i_shift    (w_shift),
        .i_bit      (dinout_in),
        .o_msb      (dinout_out),
        .o_last     (w_last),
        .o_data_nxt (w_shift_data)
    );

    // r_ph is the strobe phase of a two-cycle item: 0 = setup, 1 = WE/RE high.
    always_comb begin
        w_state_nxt   = r_state;
        w_ph_nxt      = 1'b0;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE:     if (w_accept) w_state_nxt = S_CE_SETUP;
            S_CE_SETUP: w_state_nxt = S_CMD;
            S_CMD: begin
                if (!r_ph) w_ph_nxt = 1'b1;
                else begin
                    w_state_nxt = S_ADDR;
                    w_cnt_nxt   = CNT_W'(2);
                end
            end
            S_ADDR: begin
                if (!r_ph)               w_ph_nxt    = 1'b1;
                else if (r_cnt == '0)    w_state_nxt = r_op ? S_CONF : S_WDATA;
                else                     w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
            S_WDATA: begin
                if (!r_ph)       w_ph_nxt    = 1'b1;
                else if (w_last) w_state_nxt = S_CONF;
            end
            S_CONF: begin
                if (!r_ph) w_ph_nxt = 1'b1;
                else begin
                    w_state_nxt = S_GUARD;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            S_GUARD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_WAIT_RB;
                    w_cnt_nxt   = CNT_W'(BUSY_TIMEOUT - 1);
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_WAIT_RB: begin
                if (RB) w_state_nxt = r_op ? S_RDATA : S_DONE;
                else if (r_cnt == '0) begin
                    w_state_nxt   = S_DONE;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_RDATA: begin
                if (!r_ph)       w_ph_nxt    = 1'b1;
                else if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_io_nxt = 4'b0000;
        case (w_state_nxt)
            S_CMD:  w_io_nxt = r_op ? CMD_READ : CMD_WRITE;
            S_CONF: w_io_nxt = r_op ? CMD_RCONF : CMD_WCONF;
            S_ADDR: begin
                if (w_cnt_nxt == CNT_W'(2))      w_io_nxt = r_addr[11:8];
                else if (w_cnt_nxt == CNT_W'(1)) w_io_nxt = r_addr[7:4];
                else                             w_io_nxt = r_addr[3:0];
            end
            default: w_io_nxt = 4'b0000;
        endcase
    end

    // Outputs are decoded from the next state so every pin is a flop aligned with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ph        <= 1'b0;
            r_cnt       <= '0;
            r_op        <= 1'b0;
            r_addr      <= '0;
            req_ready   <= 1'b0;
            CE          <= 1'b1;
            CLE         <= 1'b0;
            ALE         <= 1'b0;
            WE          <= 1'b0;
            RE          <= 1'b0;
            IO          <= 4'b0000;
            io_oe       <= 1'b0;
            dinout_oe   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ph    <= w_ph_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_op   <= req_op;
                r_addr <= req_addr;
            end
            req_ready   <= (w_state_nxt == S_IDLE);
            CE          <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE);
            CLE         <= (w_state_nxt == S_CMD) || (w_state_nxt == S_CONF);
            ALE         <= (w_state_nxt == S_ADDR);
            WE          <= w_ph_nxt && ((w_state_nxt == S_CMD) || (w_state_nxt == S_ADDR) ||
                                        (w_state_nxt == S_WDATA) || (w_state_nxt == S_CONF));
            RE          <= w_ph_nxt && (w_state_nxt == S_RDATA);
            IO          <= w_io_nxt;
            io_oe       <= (w_state_nxt == S_CMD) || (w_state_nxt == S_ADDR) || (w_state_nxt == S_CONF);
            dinout_oe   <= (w_state_nxt == S_WDATA);
            rsp_valid   <= (w_state_nxt == S_DONE);
            rsp_timeout <= w_timeout_nxt;
            if (w_state_nxt == S_DONE)
                rsp_rdata <= (r_op && !w_timeout_nxt) ? w_shift_data : '0;
        end
    end

endmodule

// File: tb/tb_rram_host_seq.sv
// Directed, table-driven bench for rram_host_seq with a small RRAM device model for RB and read data.
module tb_rram_host_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_op = 1'b0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        CE, CLE, ALE, WE, RE;
    logic [3:0]  IO;
    logic        io_oe, dinout_out, dinout_oe;
    logic        dinout_in = 1'b0;
    logic        RB = 1'b1;

    rram_host_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .CE          (CE),
        .CLE         (CLE),
        .ALE         (ALE),
        .WE          (WE),
        .RE          (RE),
        .IO          (IO),
        .io_oe       (io_oe),
        .dinout_out  (dinout_out),
        .dinout_oe   (dinout_oe),
        .dinout_in   (dinout_in),
        .RB          (RB)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    typedef struct {
        logic        op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rb_low;     // busy cycles seen in WAIT_RB; -1 = never ready
        int          exp_cyc;
        logic        exp_to;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    always @(negedge clk) if (io_oe && dinout_oe) overlap++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int cyc, ridx, done_cyc, wait_cyc, n, ready_bad;
        logic [3:0]  nibs[$];
        logic [3:0]  cmds[$];
        logic        bits[$];
        logic [31:0] word;
        logic [11:0] aw;
        logic [7:0]  cw;
        wait_cyc = v.op ? 14 : 78;
        ridx = 0; done_cyc = -1; ready_bad = 0; n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        req_op = v.op; req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
        RB = 1'b1; dinout_in = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        chk({tag, "_ce_setup"}, 32'({CE, CLE, ALE, WE, RE, req_ready}), 32'(6'b000000));
        while (cyc < 400) begin
            if (rsp_valid) begin done_cyc = cyc; break; end
            if (req_ready) ready_bad++;
            if (WE && ALE) nibs.push_back(IO);
            if (WE && CLE) cmds.push_back(IO);
            if (WE && dinout_oe) bits.push_back(dinout_out);
            if (RE && ridx < 32) begin dinout_in = v.rdata[31 - ridx]; ridx++; end
            RB = !(v.rb_low != 0 && cyc >= wait_cyc - 2 && (v.rb_low < 0 || cyc < wait_cyc + v.rb_low));
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_rsp_cycle"}, 32'(done_cyc), 32'(v.exp_cyc));
        chk({tag, "_timeout"}, 32'(rsp_timeout), 32'(v.exp_to));
        chk({tag, "_ce_done"}, 32'(CE), 32'(1));
        if (v.op || v.exp_to) chk({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, "_ready_busy"}, 32'(ready_bad), 32'(0));
        aw = '0;
        for (int i = 0; i < nibs.size() && i < 3; i++) aw = {aw[7:0], nibs[i]};
        chk({tag, "_nib_count"}, 32'(nibs.size()), 32'(3));
        chk({tag, "_addr_nibs"}, 32'(aw), 32'(v.addr));
        cw = '0;
        for (int i = 0; i < cmds.size() && i < 2; i++) cw = {cw[3:0], cmds[i]};
        chk({tag, "_cmds"}, 32'({cmds.size() == 2, cw}), v.op ? 32'h113 : 32'h142);
        word = '0;
        for (int i = 0; i < bits.size() && i < 32; i++) word = {word[30:0], bits[i]};
        chk({tag, "_bit_count"}, 32'(bits.size()), v.op ? 32'(0) : 32'(32));
        if (!v.op) chk({tag, "_wbits"}, word, v.wdata);
        RB = 1'b1;
        @(negedge clk);
        chk({tag, "_idle_after"}, 32'({req_ready, CE, rsp_valid, rsp_timeout}), 32'(4'b1100));
        if (v.op && !v.exp_to) begin
            repeat (3) @(negedge clk);
            chk({tag, "_rdata_hold"}, rsp_rdata, v.exp_rdata);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, n, bad;
        vecs[0] = '{1'b0, 12'h081, 32'hA5D6ACB5, 32'h0,        0,  79, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 12'h081, 32'h0,        32'h3C3C00FF, 0,  79, 1'b0, 32'h3C3C00FF};
        vecs[2] = '{1'b0, 12'hFFF, 32'h12345678, 32'h0,        10, 89, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 12'hA5C, 32'h0,        32'h80000001, 5,  84, 1'b0, 32'h80000001};
        vecs[4] = '{1'b1, 12'h555, 32'h0,        32'hFFFFFFFF, -1, 78, 1'b1, 32'h0};
        vecs[5] = '{1'b0, 12'h3E7, 32'hDEADBEEF, 32'h0,        -1, 142, 1'b1, 32'h0};

        #23;
        chk("rst_ctrl", 32'({CE, CLE, ALE, WE, RE, io_oe, dinout_oe, dinout_out, rsp_valid, rsp_timeout, req_ready}),
            32'(11'b10000000000));
        chk("rst_io", 32'(IO), 32'(0));
        chk("rst_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'(1));

        for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("v%0d", i));

        // abort a write at cycle 30 with an asynchronous reset pulse
        req_op = 1'b0; req_addr = 12'h081; req_wdata = 32'hA5D6ACB5; req_valid = 1'b1; RB = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (29) @(negedge clk);
        chk("midrst_busy", 32'({CE, dinout_oe}), 32'(2'b01));
        rst_n = 1'b0;
        #1;
        chk("midrst_async", 32'({CE, CLE, ALE, WE, RE, io_oe, dinout_oe, dinout_out, rsp_valid, req_ready}),
            32'(10'b1000000000));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 32'(req_ready), 32'(1));
        n = 0;
        repeat (100) begin @(negedge clk); if (rsp_valid) n++; end
        chk("midrst_no_rsp", 32'(n), 32'(0));
        run_txn(vecs[0], "after_rst");

        // back-to-back: req_valid held high across a write and a following read
        req_op = 1'b0; req_addr = 12'h081; req_wdata = 32'hA5D6ACB5; req_valid = 1'b1;
        RB = 1'b1; dinout_in = 1'b1;
        @(negedge clk);
        cyc = 1; bad = 0;
        req_op = 1'b1; req_addr = 12'h123;
        while (cyc < 300 && !rsp_valid) begin
            if (req_ready) bad++;
            @(negedge clk);
            cyc++;
        end
        chk("b2b_first_cycle", 32'(cyc), 32'(79));
        @(negedge clk);
        chk("b2b_ready_after_done", 32'(req_ready), 32'(1));
        @(negedge clk);
        chk("b2b_second_accept", 32'({CE, req_ready}), 32'(2'b00));
        req_valid = 1'b0;
        cyc = 81;
        while (cyc < 400 && !rsp_valid) begin
            if (req_ready) bad++;
            @(negedge clk);
            cyc++;
        end
        chk("b2b_second_cycle", 32'(cyc), 32'(159));
        chk("b2b_second_rdata", rsp_rdata, 32'hFFFFFFFF);
        chk("b2b_no_ready_busy", 32'(bad), 32'(0));
        dinout_in = 1'b0;
        repeat (2) @(negedge clk);

        chk("oe_overlap", 32'(overlap), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
